prng_arbiter: RTL and testbench



---
 rtl/prng_arbiter.sv | 113 +++++++++++
 tb/tb_prng_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/prng_arbiter.sv
// rtl/prng_arbiter.sv - round-robin random byte server around a shared LCG
// One LCG step per grant or warm-up cycle, so no two consumers ever see the same draw.
module prng_arbiter #(
    parameter int              N      = 32,
    parameter longint unsigned A      = 1103515245,
    parameter longint unsigned C      = 12345,
    parameter int              NREQ   = 4,
    parameter int              OUT_W  = 8,
    parameter int              WARMUP = 16
) (
    input  logic              clk50M,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    output logic [NREQ-1:0]   ack,
    output logic [OUT_W-1:0]  rand_out,
    input  logic              seed_load,
    input  logic [N-1:0]      seed,
    output logic              busy
);

    localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WCW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam logic [N-1:0]   A_L       = N'(A);
    localparam logic [N-1:0]   C_L       = N'(C);
    localparam logic [WCW-1:0] WARM_LAST = WCW'((WARMUP > 0) ? WARMUP - 1 : 0);
    localparam logic [PW-1:0]  LAST_REQ  = PW'(NREQ - 1);

    typedef enum logic {ST_WARM, ST_SERVE} fsm_e;
    localparam fsm_e START_ST = (WARMUP == 0) ? ST_SERVE : ST_WARM;

    fsm_e              fsm_q, fsm_d;
    logic [N-1:0]      state_q, state_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [OUT_W-1:0]  rand_q, rand_d;
    logic [WCW-1:0]    warm_cnt_q, warm_cnt_d;

    logic [N-1:0]      lcg_next;
    logic [NREQ-1:0]   eligible;
    logic              found;
    logic [PW-1:0]     winner;
    logic [PW-1:0]     idx;

    assign lcg_next = A_L * state_q + C_L;

    // Requesters acked last cycle are masked so a held req cannot take back-to-back grants.
    always_comb begin
        eligible = req & ~ack_q;
        found    = 1'b0;
        winner   = '0;
        idx      = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = PW'((int'(rr_ptr_q) + i) % NREQ);
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_ff @(posedge clk50M) begin
        if (rst) begin
            fsm_q      <= START_ST;
            state_q    <= N'(1);
            rr_ptr_q   <= '0;
            ack_q      <= '0;
            rand_q     <= '0;
            warm_cnt_q <= '0;
        end else begin
            fsm_q      <= fsm_d;
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            ack_q      <= ack_d;
            rand_q     <= rand_d;
            warm_cnt_q <= warm_cnt_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        if (seed_load) begin
            fsm_d = START_ST;
        end else if (fsm_q == ST_WARM && warm_cnt_q == WARM_LAST) begin
            fsm_d = ST_SERVE;
        end
    end

    // A reseed overrides any grant this cycle; the losing request simply stays pending.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        ack_d      = '0;
        rand_d     = rand_q;
        warm_cnt_d = warm_cnt_q;
        if (seed_load) begin
            state_d    = seed;
            warm_cnt_d = '0;
        end else if (fsm_q == ST_WARM) begin
            state_d    = lcg_next;
            warm_cnt_d = (warm_cnt_q == WARM_LAST) ? '0 : warm_cnt_q + 1'b1;
        end else if (found) begin
            ack_d    = NREQ'(1) << winner;
            rand_d   = state_q[N-1 -: OUT_W];
            state_d  = lcg_next;
            rr_ptr_d = (winner == LAST_REQ) ? '0 : winner + 1'b1;
        end
    end

    assign ack      = ack_q;
    assign rand_out = rand_q;
    assign busy     = (fsm_q == ST_WARM);

endmodule

// File: tb/tb_prng_arbiter.sv
// tb/tb_prng_arbiter.sv - scoreboard bench for prng_arbiter, no-warm-up and 16-step warm-up builds
module tb_prng_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, seed_load0, busy0;
    logic [3:0]  req0, ack0;
    logic [7:0]  rand0;
    logic [31:0] seed0;

    logic        rst16, seed_load16, busy16;
    logic [3:0]  req16, ack16;
    logic [7:0]  rand16;
    logic [31:0] seed16;

    prng_arbiter #(.WARMUP(0)) dut0 (
        .clk50M(clk), .rst(rst0), .req(req0), .ack(ack0), .rand_out(rand0),
        .seed_load(seed_load0), .seed(seed0), .busy(busy0)
    );

    prng_arbiter #(.WARMUP(16)) dut16 (
        .clk50M(clk), .rst(rst16), .req(req16), .ack(ack16), .rand_out(rand16),
        .seed_load(seed_load16), .seed(seed16), .busy(busy16)
    );

    int checks = 0;
    int errors = 0;
    logic [11:0] exp0_q[$];
    logic [11:0] exp16_q[$];

    function automatic logic [31:0] lcg(input logic [31:0] s);
        return s * 32'd1103515245 + 32'd12345;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Every grant must match the oldest outstanding expectation; a grant with none queued is an error.
    always @(negedge clk) begin
        logic [11:0] e;
        if (ack0 != 4'b0) begin
            checks++;
            if (exp0_q.size() == 0) begin
                errors++;
                $display("FAIL dut0_unexpected_grant: got ack=%b rand=%h expected no grant", ack0, rand0);
            end else begin
                e = exp0_q.pop_front();
                if ({ack0, rand0} !== e) begin
                    errors++;
                    $display("FAIL dut0_grant: got ack=%b rand=%h expected ack=%b rand=%h",
                             ack0, rand0, e[11:8], e[7:0]);
                end
            end
        end
        if (ack16 != 4'b0) begin
            checks++;
            if (exp16_q.size() == 0) begin
                errors++;
                $display("FAIL dut16_unexpected_grant: got ack=%b rand=%h expected no grant", ack16, rand16);
            end else begin
                e = exp16_q.pop_front();
                if ({ack16, rand16} !== e) begin
                    errors++;
                    $display("FAIL dut16_grant: got ack=%b rand=%h expected ack=%b rand=%h",
                             ack16, rand16, e[11:8], e[7:0]);
                end
            end
        end
    end

    task automatic warm16_then_grant(input logic [7:0] first_rand);
        exp16_q.push_back({4'b0001, first_rand});
        for (int i = 0; i < 16; i++) begin
            check("busy16_warm", {31'b0, busy16}, 32'd1);
            tick();
        end
        check("busy16_serve", {31'b0, busy16}, 32'd0);
        tick();
        req16 = 4'b0000;
        tick();
    endtask

    initial begin
        logic [31:0] s;
        logic [7:0]  top16;
        rst0 = 1'b1; seed_load0 = 1'b0; req0 = '0; seed0 = '0;
        rst16 = 1'b1; seed_load16 = 1'b0; req16 = '0; seed16 = '0;
        tick();
        rst0 = 1'b0;

        // Reset state, no warm-up
        check("rst_ack0", {28'b0, ack0}, 32'd0);
        check("rst_rand0", {24'b0, rand0}, 32'd0);
        check("rst_busy0", {31'b0, busy0}, 32'd0);
        check("rst_busy16", {31'b0, busy16}, 32'd1);

        // Single grants on requester 0
        req0 = 4'b0001; exp0_q.push_back({4'b0001, 8'h00});
        tick(); req0 = '0; tick();
        req0 = 4'b0001; exp0_q.push_back({4'b0001, 8'h41});
        tick(); req0 = '0; tick();

        // Round robin over all four requesters
        rst0 = 1'b1; tick(); rst0 = 1'b0;
        s = 32'd1;
        for (int i = 0; i < 5; i++) begin
            exp0_q.push_back({4'b0001 << (i % 4), s[31:24]});
            s = lcg(s);
        end
        req0 = 4'b1111;
        repeat (5) tick();
        req0 = '0; tick();

        // Single held requester: every other cycle
        rst0 = 1'b1; tick(); rst0 = 1'b0;
        exp0_q.push_back({4'b0100, 8'h00});
        exp0_q.push_back({4'b0100, 8'h41});
        req0 = 4'b0100;
        repeat (4) tick();
        req0 = '0; tick();

        // Reseed wins over a simultaneous request
        rst0 = 1'b1; tick(); rst0 = 1'b0;
        seed_load0 = 1'b1; seed0 = 32'hFFFF_FFFF; req0 = 4'b0010;
        tick();
        seed_load0 = 1'b0;
        check("seed_no_ack", {28'b0, ack0}, 32'd0);
        exp0_q.push_back({4'b0010, 8'hFF});
        exp0_q.push_back({4'b0010, 8'hBE});
        repeat (3) tick();
        req0 = '0; tick();

        // Reset in the middle of a grant
        rst0 = 1'b1; tick(); rst0 = 1'b0;
        exp0_q.push_back({4'b0001, 8'h00});
        exp0_q.push_back({4'b0010, 8'h41});
        req0 = 4'b1111;
        tick(); tick();
        rst0 = 1'b1; tick(); rst0 = 1'b0;
        check("rst_grant_ack0", {28'b0, ack0}, 32'd0);
        check("rst_grant_rand0", {24'b0, rand0}, 32'd0);
        exp0_q.push_back({4'b0001, 8'h00});
        tick();
        req0 = '0; tick();

        // 16-step warm-up with requests held throughout
        s = 32'd1;
        for (int i = 0; i < 16; i++) s = lcg(s);
        top16 = s[31:24];
        req16 = 4'b1111;
        tick();
        rst16 = 1'b0;
        warm16_then_grant(top16);

        // Reset during a pending grant, then during warm-up; count restarts from zero
        req16 = 4'b0001; rst16 = 1'b1;
        tick();
        check("rst_grant_ack16", {28'b0, ack16}, 32'd0);
        check("rst_grant_rand16", {24'b0, rand16}, 32'd0);
        check("rst_grant_busy16", {31'b0, busy16}, 32'd1);
        rst16 = 1'b0; req16 = 4'b1111;
        repeat (5) tick();
        rst16 = 1'b1; tick(); rst16 = 1'b0;
        warm16_then_grant(top16);

        repeat (2) tick();
        checks++;
        if (exp0_q.size() != 0) begin
            errors++;
            $display("FAIL dut0_missing_grants: got %0d outstanding expected 0", exp0_q.size());
        end
        checks++;
        if (exp16_q.size() != 0) begin
            errors++;
            $display("FAIL dut16_missing_grants: got %0d outstanding expected 0", exp16_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
